// File: rtl/frame_capture_ctrl.sv
// Single-frame capture controller: waits for a frame start, converts active
// RGB888 pixels to RGB565 and streams them as linear-addressed frame-buffer
// writes, then flags completion at the following frame start.
module frame_capture_ctrl #(
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_de,
  input  logic [23:0]       i_data,
  input  logic              vs_fall,
  input  logic              cap_req,
  output logic              cap_busy,
  output logic              cap_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [9:0]        pix_x,
  output logic [9:0]        pix_y,
  output logic              frame_err
);

  // One extra bit so a full frame count (which may equal 2^ADDR_W) fits.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [9:0]       H_LIM     = 10'(H_ACTIVE);
  localparam logic [9:0]       V_LIM     = 10'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_STEP    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(H_ACTIVE * V_ACTIVE);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [9:0]        x;
    logic [9:0]        y;
  } wr_beat_t;

  state_t state, state_nxt;

  logic [9:0]       x_cnt, y_cnt;
  logic [CNT_W-1:0] wr_cnt;     // pixels actually written this capture
  logic [CNT_W-1:0] addr_cnt;   // address of the next in-range pixel
  logic [CNT_W-1:0] line_base;  // address of column 0 on the current line
  logic             de_d;
  logic             line_seen;

  logic     enter_capture, cap_end, pix_vld, line_end, in_range;
  wr_beat_t beat;

  // Bits of the RGB888 input dropped by the RGB565 packing.
  logic unused_lsbs;
  assign unused_lsbs = ^{i_data[18:16], i_data[9:8], i_data[2:0]};

  assign enter_capture = (state == ARMED) && vs_fall;
  assign cap_end       = (state == CAPTURE) && vs_fall;
  // The terminating frame start abandons anything still on the bus.
  assign pix_vld       = (state == CAPTURE) && !vs_fall && i_de;
  assign line_end      = (state == CAPTURE) && !vs_fall && de_d && !i_de;
  assign in_range      = (x_cnt < H_LIM) && (y_cnt < V_LIM);

  assign beat.addr = addr_cnt[ADDR_W-1:0];
  assign beat.data = {i_data[23:19], i_data[15:10], i_data[7:3]};
  assign beat.x    = x_cnt;
  assign beat.y    = y_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: request arms, frame starts open and close the capture.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cap_req) state_nxt = ARMED;
      ARMED:   if (vs_fall) state_nxt = CAPTURE;
      CAPTURE: if (vs_fall) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel position and address tracking; counters only move in CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      wr_cnt    <= '0;
      addr_cnt  <= '0;
      line_base <= '0;
      de_d      <= 1'b0;
      line_seen <= 1'b0;
    end else if (enter_capture) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      wr_cnt    <= '0;
      addr_cnt  <= '0;
      line_base <= '0;
      de_d      <= 1'b0;
      line_seen <= 1'b0;
    end else if ((state == CAPTURE) && !vs_fall) begin
      de_d <= i_de;
      if (pix_vld) begin
        line_seen <= 1'b1;
        // Saturate so an absurdly long line cannot wrap back into range.
        if (x_cnt != 10'h3FF) x_cnt <= x_cnt + 1'b1;
        if (in_range) begin
          addr_cnt <= addr_cnt + 1'b1;
          wr_cnt   <= wr_cnt + 1'b1;
        end
      end else if (line_end) begin
        x_cnt     <= '0;
        line_seen <= 1'b0;
        if (line_seen) begin
          if (y_cnt != 10'h3FF) y_cnt <= y_cnt + 1'b1;
          // Realign to the next row even if this line was short, so the
          // address always matches y*H_ACTIVE + x without a multiplier.
          if (y_cnt < V_LIM) begin
            line_base <= line_base + H_STEP;
            addr_cnt  <= line_base + H_STEP;
          end
        end
      end
    end
  end

  // Registered write port and pixel coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      pix_x   <= '0;
      pix_y   <= '0;
    end else begin
      wr_en <= pix_vld && in_range;
      if (pix_vld) begin
        wr_addr <= beat.addr;
        wr_data <= beat.data;
        pix_x   <= beat.x;
        pix_y   <= beat.y;
      end
    end
  end

  // Handshake and sticky error status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_busy  <= 1'b0;
      cap_done  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cap_busy <= (state_nxt == ARMED) || (state_nxt == CAPTURE);
      cap_done <= cap_end;
      if ((state == IDLE) && cap_req)
        frame_err <= 1'b0;
      else if (pix_vld && !in_range)
        frame_err <= 1'b1;
      else if (cap_end && (wr_cnt != PIX_TOTAL))
        frame_err <= 1'b1;
    end
  end

endmodule
